// File: rtl/button_event_arbiter_pkg.sv
// Shared constants and helpers for the push-button event front end.
package button_event_arbiter_pkg;

    localparam int   N_CH        = 4;
    localparam int   CH_W        = 2;
    localparam logic EVT_RELEASE = 1'b0;
    localparam logic EVT_PRESS   = 1'b1;

    typedef logic [CH_W-1:0] ch_t;

    // First requesting channel at or above ptr, wrapping; the lowest offset wins.
    function automatic ch_t rr_pick(input logic [N_CH-1:0] req, input ch_t ptr);
        ch_t pick;
        ch_t idx;
        pick = ptr;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = ptr + ch_t'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    function automatic ch_t next_ch(input ch_t ch);
        return ch + ch_t'(1);
    endfunction

endpackage

// File: rtl/button_event_arbiter_debounce_channel.sv
// One button line: two-flop synchroniser, tick-driven debounce counter and
// debounced level; edge_pulse is combinational so the slot loads alongside Level.
module debounce_channel
    import button_event_arbiter_pkg::*;
#(
    parameter int STABLE_TICKS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic level,
    output logic edge_pulse,
    output logic edge_type
);

    localparam int CNT_W = $clog2(STABLE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [1:0]       sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic             level_r;
    logic             differ_s;
    logic             accept_s;

    // Decide whether this tick completes a run of differing samples.
    always_comb begin
        differ_s = sync_r[1] ^ level_r;
        accept_s = tick & differ_s & (cnt_r == CNT_LAST);
    end

    // Synchroniser, debounce counter and accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r  <= 2'b00;
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], raw};
            if (tick) begin
                if (!differ_s) begin
                    cnt_r <= {CNT_W{1'b0}};
                end else if (cnt_r == CNT_LAST) begin
                    level_r <= ~level_r;
                    cnt_r   <= {CNT_W{1'b0}};
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end
        end
    end

    assign level      = level_r;
    assign edge_pulse = accept_s;
    assign edge_type  = level_r ? EVT_RELEASE : EVT_PRESS;

endmodule

// File: rtl/button_event_arbiter.sv
// Four debounced buttons serialised through per-channel pending slots and a
// round-robin arbiter onto one valid/ready event port.
module button_event_arbiter
    import button_event_arbiter_pkg::*;
#(
    parameter int CLK_DIV      = 50000,
    parameter int STABLE_TICKS = 10
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [N_CH-1:0] Input,
    output logic [N_CH-1:0] Level,
    output logic            Evt_Valid,
    input  logic            Evt_Ready,
    output logic [CH_W-1:0] Evt_Ch,
    output logic            Evt_Press,
    output logic [N_CH-1:0] Overrun,
    input  logic            Clr_Ovr
);

    localparam int PRE_W = $clog2(CLK_DIV);

    logic [PRE_W-1:0] presc_r;
    logic             tick_s;
    logic [N_CH-1:0]  level_s, edge_s, type_s;
    logic [N_CH-1:0]  pend_r, type_r, ovr_r;
    logic [N_CH-1:0]  pend_nxt_s, type_nxt_s, ovr_set_s, ovr_nxt_s, gnt_oh_s;
    logic             valid_r, press_r, free_s, gnt_any_s;
    ch_t              ch_r, ptr_r, gnt_ch_s;

    assign tick_s = (presc_r == PRE_W'(CLK_DIV - 1));

    // Shared sample-tick prescaler.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            presc_r <= {PRE_W{1'b0}};
        end else if (tick_s) begin
            presc_r <= {PRE_W{1'b0}};
        end else begin
            presc_r <= presc_r + PRE_W'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(.STABLE_TICKS(STABLE_TICKS)) u_deb (
            .clk       (Clk),
            .rst       (Rst),
            .raw       (Input[g]),
            .tick      (tick_s),
            .level     (level_s[g]),
            .edge_pulse(edge_s[g]),
            .edge_type (type_s[g])
        );
    end

    // Arbitration and slot update; a fresh edge always wins over a grant.
    always_comb begin
        free_s    = ~valid_r | Evt_Ready;
        gnt_any_s = |pend_r;
        gnt_ch_s  = rr_pick(pend_r, ptr_r);
        if (free_s && gnt_any_s) begin
            gnt_oh_s = N_CH'(1) << gnt_ch_s;
        end else begin
            gnt_oh_s = {N_CH{1'b0}};
        end
        for (int i = 0; i < N_CH; i++) begin
            pend_nxt_s[i] = pend_r[i];
            type_nxt_s[i] = type_r[i];
            ovr_set_s[i]  = 1'b0;
            if (edge_s[i]) begin
                pend_nxt_s[i] = 1'b1;
                type_nxt_s[i] = type_s[i];
                ovr_set_s[i]  = pend_r[i] & ~gnt_oh_s[i];
            end else if (gnt_oh_s[i]) begin
                pend_nxt_s[i] = 1'b0;
            end else begin
                pend_nxt_s[i] = pend_r[i];
            end
        end
        if (Clr_Ovr) begin
            ovr_nxt_s = ovr_set_s;
        end else begin
            ovr_nxt_s = ovr_set_s | ovr_r;
        end
    end

    // Pending slots, overrun flags and the event output register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pend_r  <= {N_CH{1'b0}};
            type_r  <= {N_CH{1'b0}};
            ovr_r   <= {N_CH{1'b0}};
            valid_r <= 1'b0;
            ch_r    <= {CH_W{1'b0}};
            press_r <= 1'b0;
            ptr_r   <= {CH_W{1'b0}};
        end else begin
            pend_r <= pend_nxt_s;
            type_r <= type_nxt_s;
            ovr_r  <= ovr_nxt_s;
            if (free_s) begin
                if (gnt_any_s) begin
                    valid_r <= 1'b1;
                    ch_r    <= gnt_ch_s;
                    press_r <= type_r[gnt_ch_s];
                    ptr_r   <= next_ch(gnt_ch_s);
                end else begin
                    valid_r <= 1'b0;
                end
            end
        end
    end

    assign Level     = level_s;
    assign Evt_Valid = valid_r;
    assign Evt_Ch    = ch_r;
    assign Evt_Press = press_r;
    assign Overrun   = ovr_r;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with CLK_DIV=4, STABLE_TICKS=3.
module tb_button_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn;
    logic [3:0] level;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_ch;
    logic       evt_press;
    logic [3:0] overrun;
    logic       clr_ovr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ev_n   = 0;
    logic [2:0] ev_log [16];

    typedef struct {
        logic [3:0]  in;
        logic [3:0]  lvl;
        int          n;
        logic [11:0] ev;   // entry k = {press, ch} at bits [3k+2:3k]
    } vec_t;

    vec_t tbl [6];

    always #5 clk = ~clk;

    button_event_arbiter #(.CLK_DIV(4), .STABLE_TICKS(3)) dut (
        .Clk      (clk),
        .Rst      (rst),
        .Input    (btn),
        .Level    (level),
        .Evt_Valid(evt_valid),
        .Evt_Ready(evt_ready),
        .Evt_Ch   (evt_ch),
        .Evt_Press(evt_press),
        .Overrun  (overrun),
        .Clr_Ovr  (clr_ovr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge: inputs are final for the next posedge, so log a handshake then advance.
    task automatic step();
        if (evt_valid && evt_ready && ev_n < 16) begin
            ev_log[ev_n] = {evt_press, evt_ch};
            ev_n++;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        btn       = 4'b0000;
        evt_ready = 1'b0;
        clr_ovr   = 1'b0;
        rst       = 1'b1;
        step();
        rst  = 1'b0;
        cyc  = 0;
        ev_n = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_level"}, 32'(level), 32'h0);
        chk({tag, "_valid"}, 32'(evt_valid), 32'h0);
        chk({tag, "_ch"}, 32'(evt_ch), 32'h0);
        chk({tag, "_press"}, 32'(evt_press), 32'h0);
        chk({tag, "_overrun"}, 32'(overrun), 32'h0);
    endtask

    initial begin
        int p;
        int q1;
        int d;
        logic seen;

        tbl[0] = '{4'b1111, 4'b1111, 4, {3'b111, 3'b110, 3'b101, 3'b100}};
        tbl[1] = '{4'b0000, 4'b0000, 4, {3'b011, 3'b010, 3'b001, 3'b000}};
        tbl[2] = '{4'b0100, 4'b0100, 1, {9'd0, 3'b110}};
        tbl[3] = '{4'b0110, 4'b0110, 1, {9'd0, 3'b101}};
        tbl[4] = '{4'b1001, 4'b1001, 4, {3'b001, 3'b100, 3'b111, 3'b010}};
        tbl[5] = '{4'b0000, 4'b0000, 2, {6'd0, 3'b000, 3'b011}};

        rst = 1'b1; btn = 4'b0000; evt_ready = 1'b0; clr_ovr = 1'b0;
        @(negedge clk);
        do_reset();
        chk_reset_outputs("reset");

        // Table: each row changes Input, runs 40 cycles with Evt_Ready high, then checks.
        evt_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            btn  = tbl[r].in;
            ev_n = 0;
            repeat (40) step();
            chk($sformatf("row%0d_level", r), 32'(level), 32'(tbl[r].lvl));
            chk($sformatf("row%0d_count", r), 32'(ev_n), 32'(tbl[r].n));
            chk($sformatf("row%0d_overrun", r), 32'(overrun), 32'h0);
            for (int k = 0; k < tbl[r].n; k++) begin
                chk($sformatf("row%0d_ev%0d", r, k), 32'(ev_log[k]), 32'(tbl[r].ev[3*k +: 3]));
            end
        end

        // Bounce on ch0: 5-cycle half periods never give three agreeing ticks.
        do_reset();
        evt_ready = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 8; j++) begin
            btn[0] = ~btn[0];
            repeat (5) begin
                step();
                seen = seen | level[0];
            end
        end
        btn = 4'b0000;
        repeat (20) step();
        chk("bounce_level_seen", 32'(seen), 32'h0);
        chk("bounce_level", 32'(level), 32'h0);
        chk("bounce_events", 32'(ev_n), 32'h0);

        // Backpressure holds ch1, then ch3 press+release overruns its slot.
        do_reset();
        btn = 4'b0010;
        repeat (20) step();
        chk("bp_valid", 32'(evt_valid), 32'h1);
        chk("bp_ch", 32'(evt_ch), 32'h1);
        chk("bp_press", 32'(evt_press), 32'h1);
        btn = 4'b1010;
        repeat (20) step();
        chk("bp_hold_ch", 32'(evt_ch), 32'h1);
        chk("bp_hold_press", 32'(evt_press), 32'h1);
        chk("bp_no_ovr_yet", 32'(overrun), 32'h0);
        btn = 4'b0010;
        repeat (20) step();
        chk("bp_ovr", 32'(overrun), 32'h8);
        chk("bp_hold_valid", 32'(evt_valid), 32'h1);
        evt_ready = 1'b1;
        ev_n = 0;
        repeat (10) step();
        chk("bp_count", 32'(ev_n), 32'h2);
        chk("bp_ev0", 32'(ev_log[0]), 32'h5);
        chk("bp_ev1", 32'(ev_log[1]), 32'h3);
        chk("bp_ovr_sticky", 32'(overrun), 32'h8);
        clr_ovr = 1'b1;
        step();
        clr_ovr = 1'b0;
        chk("bp_ovr_clr", 32'(overrun), 32'h0);

        // Collision: ch2 release is decided in the very cycle ch2's press slot is granted.
        do_reset();
        btn = 4'b0010;
        repeat (20) step();
        btn = 4'b0110;
        repeat (20) step();
        btn = 4'b0010;
        p  = cyc + 1;
        q1 = ((p + 2 + 3) / 4) * 4;
        d  = q1 + 8;
        while (cyc + 1 < d) step();
        chk("col_level_before", 32'(level[2]), 32'h1);
        chk("col_ch_before", 32'(evt_ch), 32'h1);
        evt_ready = 1'b1;
        ev_n = 0;
        step();
        chk("col_level_after", 32'(level[2]), 32'h0);
        repeat (6) step();
        chk("col_count", 32'(ev_n), 32'h3);
        chk("col_ev0", 32'(ev_log[0]), 32'h5);
        chk("col_ev1", 32'(ev_log[1]), 32'h6);
        chk("col_ev2", 32'(ev_log[2]), 32'h2);
        chk("col_overrun", 32'(overrun), 32'h0);

        // Reset while an event is presented and two slots are pending.
        do_reset();
        btn = 4'b0111;
        repeat (20) step();
        chk("mid_valid", 32'(evt_valid), 32'h1);
        chk("mid_press", 32'(evt_press), 32'h1);
        btn = 4'b0000;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_outputs("mid_rst");
        evt_ready = 1'b1;
        ev_n = 0;
        repeat (30) step();
        chk("mid_no_events", 32'(ev_n), 32'h0);
        chk("mid_level", 32'(level), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
